// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - elastic EX/MEM pipeline stage with 2-entry skid buffer (optional STALL_CNT_EN stall counter)
module ex_mem_stage #(
    parameter int          DATA_W   = 32,
    parameter int          PC_W     = 32,
    parameter int          INS_W    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [PC_W-1:0]   PC8,
    input  logic [INS_W-1:0]  Ins,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] ALUOutM,
    output logic [DATA_W-1:0] WriteDataM,
    output logic [PC_W-1:0]   PC8M,
`ifdef STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic [INS_W-1:0]  InsM
);

    localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state_q, state_d;
    logic               main_valid_q, main_valid_d;
    logic               skid_valid_q, skid_valid_d;
    logic               ready_q, ready_d;
    logic [DATA_W-1:0]  m_alu_q, m_alu_d, s_alu_q, s_alu_d;
    logic [DATA_W-1:0]  m_wd_q, m_wd_d, s_wd_q, s_wd_d;
    logic [PC_W-1:0]    m_pc_q, m_pc_d, s_pc_q, s_pc_d;
    logic [INS_W-1:0]   m_ins_q, m_ins_d, s_ins_q, s_ins_d;
    logic               in_fire, out_fire;

    assign in_fire  = valid_i & ready_q;
    assign out_fire = main_valid_q & ready_i;

    always_comb begin
        state_d = state_q;
        m_alu_d = m_alu_q;
        m_wd_d  = m_wd_q;
        m_pc_d  = m_pc_q;
        m_ins_d = m_ins_q;
        s_alu_d = s_alu_q;
        s_wd_d  = s_wd_q;
        s_pc_d  = s_pc_q;
        s_ins_d = s_ins_q;
        if (flush) begin
            // Squash: data fields hold, control-relevant fields become a NOP at RESET_PC.
            state_d = EMPTY;
            m_ins_d = '0;
            s_ins_d = '0;
            m_pc_d  = RST_PC;
            s_pc_d  = RST_PC;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        m_alu_d = ALUOut;
                        m_wd_d  = WriteData;
                        m_pc_d  = PC8;
                        m_ins_d = Ins;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_alu_d = ALUOut;
                        m_wd_d  = WriteData;
                        m_pc_d  = PC8;
                        m_ins_d = Ins;
                    end else if (in_fire) begin
                        state_d = TWO;
                        s_alu_d = ALUOut;
                        s_wd_d  = WriteData;
                        s_pc_d  = PC8;
                        s_ins_d = Ins;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d = ONE;
                        m_alu_d = s_alu_q;
                        m_wd_d  = s_wd_q;
                        m_pc_d  = s_pc_q;
                        m_ins_d = s_ins_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        main_valid_d = (state_d != EMPTY);
        skid_valid_d = (state_d == TWO);
        // ready is its own flop so MEM back-pressure never reaches EX combinationally.
        ready_d      = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= EMPTY;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            m_alu_q      <= '0;
            m_wd_q       <= '0;
            m_pc_q       <= RST_PC;
            m_ins_q      <= '0;
            s_alu_q      <= '0;
            s_wd_q       <= '0;
            s_pc_q       <= RST_PC;
            s_ins_q      <= '0;
        end else begin
            state_q      <= state_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            m_alu_q      <= m_alu_d;
            m_wd_q       <= m_wd_d;
            m_pc_q       <= m_pc_d;
            m_ins_q      <= m_ins_d;
            s_alu_q      <= s_alu_d;
            s_wd_q       <= s_wd_d;
            s_pc_q       <= s_pc_d;
            s_ins_q      <= s_ins_d;
        end
    end

    assign ready_o    = ready_q;
    assign valid_o    = main_valid_q;
    assign ALUOutM    = m_alu_q;
    assign WriteDataM = m_wd_q;
    assign PC8M       = m_pc_q;
    assign InsM       = m_ins_q;

`ifdef STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (main_valid_q && !ready_i && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed-vector self-checking bench for ex_mem_stage
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] ALUOut;
    logic [31:0] WriteData;
    logic [31:0] PC8;
    logic [31:0] Ins;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] PC8M;
    logic [31:0] InsM;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_vec = 0;
    int n_bad = 0;

    ex_mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .ALUOut     (ALUOut),
        .WriteData  (WriteData),
        .PC8        (PC8),
        .Ins        (Ins),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .PC8M       (PC8M),
`ifdef STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .InsM       (InsM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc);
        valid_i   = v;
        Ins       = ins;
        ALUOut    = alu;
        WriteData = wd;
        PC8       = pc;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        ready_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;

        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        chk("rst_pc", PC8M, 32'h0000_3000);
        chk("rst_ins", InsM, 32'h0);
        chk("rst_alu", ALUOutM, 32'h0);
        chk("rst_wd", WriteDataM, 32'h0);

        // Streaming: one beat per cycle, 1-cycle latency.
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, i, 32'h100 + i, 32'h200 + i, 32'h1000 + 4 * i);
            tick();
            chk("stream_ins", InsM, i);
            chk("stream_alu", ALUOutM, 32'h100 + i);
            chk("stream_valid", {31'b0, valid_o}, 32'd1);
            chk("stream_ready", {31'b0, ready_o}, 32'd1);
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("drain_valid", {31'b0, valid_o}, 32'd0);
        chk("drain_hold_ins", InsM, 32'd8);

        // Back-pressure: A then B, B held in skid.
        ready_i = 1'b0;
        drive(1'b1, 32'hA, 32'hAAA0, 32'hAAA1, 32'hAAA2);
        tick();
        chk("bp_a_ins", InsM, 32'hA);
        chk("bp_a_ready", {31'b0, ready_o}, 32'd1);
        drive(1'b1, 32'hB, 32'hBBB0, 32'hBBB1, 32'hBBB2);
        tick();
        chk("bp_two_ins", InsM, 32'hA);
        chk("bp_two_ready", {31'b0, ready_o}, 32'd0);
        drive(1'b1, 32'hE, 32'hEEE0, 32'hEEE1, 32'hEEE2);
        tick();
        chk("bp_hold_ins", InsM, 32'hA);
        chk("bp_hold_valid", {31'b0, valid_o}, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        ready_i = 1'b1;
        tick();
        chk("bp_b_ins", InsM, 32'hB);
        chk("bp_b_wd", WriteDataM, 32'hBBB1);
        chk("bp_b_pc", PC8M, 32'hBBB2);
        chk("bp_b_ready", {31'b0, ready_o}, 32'd1);
        tick();
        chk("bp_empty_valid", {31'b0, valid_o}, 32'd0);

        // Flush while in TWO with a beat offered.
        ready_i = 1'b0;
        drive(1'b1, 32'h1A, 32'h1A0, 32'h1A1, 32'h1A2);
        tick();
        drive(1'b1, 32'h1B, 32'h1B0, 32'h1B1, 32'h1B2);
        tick();
        chk("fl_pre_ready", {31'b0, ready_o}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 32'h1C, 32'h1C0, 32'h1C1, 32'h1C2);
        tick();
        flush = 1'b0;
        chk("fl_valid", {31'b0, valid_o}, 32'd0);
        chk("fl_ins", InsM, 32'h0);
        chk("fl_pc", PC8M, 32'h0000_3000);
        chk("fl_alu_hold", ALUOutM, 32'h1A0);
        chk("fl_ready", {31'b0, ready_o}, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        ready_i = 1'b1;
        tick();
        chk("fl_no_c", {31'b0, valid_o}, 32'd0);
        tick();
        chk("fl_no_c2", {31'b0, valid_o}, 32'd0);

        // Asynchronous reset mid-cycle while in TWO.
        ready_i = 1'b0;
        drive(1'b1, 32'h2A, 32'h2A0, 32'h2A1, 32'h2A2);
        tick();
        drive(1'b1, 32'h2B, 32'h2B0, 32'h2B1, 32'h2B2);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("ar_pre_ready", {31'b0, ready_o}, 32'd0);
        #3 rst = 1'b1;
        #1;
        chk("ar_valid", {31'b0, valid_o}, 32'd0);
        chk("ar_ready", {31'b0, ready_o}, 32'd1);
        chk("ar_pc", PC8M, 32'h0000_3000);
        chk("ar_ins", InsM, 32'h0);
        chk("ar_alu", ALUOutM, 32'h0);
        tick();
        rst = 1'b0;
        ready_i = 1'b1;
        drive(1'b1, 32'h3D, 32'h3D0, 32'h3D1, 32'h3D2);
        tick();
        chk("ar_d_ins", InsM, 32'h3D);
        chk("ar_d_valid", {31'b0, valid_o}, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        chk("ar_d_drain", {31'b0, valid_o}, 32'd0);
        chk("ar_d_no_2b", InsM, 32'h3D);

`ifdef STALL_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("sc_reset", stall_cnt, 32'd0);
        ready_i = 1'b0;
        drive(1'b1, 32'h4A, 32'h4A0, 32'h4A1, 32'h4A2);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        chk("sc_start", stall_cnt, 32'd0);
        repeat (5) tick();
        chk("sc_five", stall_cnt, 32'd5);
        flush = 1'b1;
        ready_i = 1'b1;
        tick();
        flush = 1'b0;
        chk("sc_flush", stall_cnt, 32'd5);
        rst = 1'b1;
        #1;
        chk("sc_rst", stall_cnt, 32'd0);
        tick();
        rst = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Parametrised, elastic EX/MEM pipeline stage for the MIPS core. It carries ALU result, store data, PC+8 and instruction from EX to MEM. It uses a valid/ready handshake on both sides and a 2-entry skid buffer, so back-pressure from MEM never creates a combinational ready path into EX. A synchronous flush squashes in-flight beats on branch/exception redirect.

Parameters:
DATA_W, 32, width of ALUOut and WriteData fields
PC_W, 32, width of PC8 field
INS_W, 32, width of instruction field
RESET_PC, 32'h00003000, value loaded into PC8 registers on reset and flush (truncated/extended to PC_W)

Ports:
clk  input  1  single clock; all state updates on posedge
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous squash of all held beats
valid_i  input  1  EX presents a beat
ready_o  output  1  stage can accept a beat
ALUOut  input  DATA_W  ALU result from EX
WriteData  input  DATA_W  store data from EX
PC8  input  PC_W  PC+8 from EX
Ins  input  INS_W  instruction from EX
valid_o  output  1  head beat valid toward MEM
ready_i  input  1  MEM accepts head beat
ALUOutM  output  DATA_W  head ALU result
WriteDataM  output  DATA_W  head store data
PC8M  output  PC_W  head PC+8
InsM  output  INS_W  head instruction

Behaviour:
- Storage: main register (drives outputs) plus skid register; each has a valid bit. Outputs come directly from main flops (no muxing).
- in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- ready_o = !skid_valid, taken directly from a flop. valid_o = main_valid.
- State machine: EMPTY (no beats), ONE (main only), TWO (main+skid).
- EMPTY: in_fire -> ONE, main <= inputs. Otherwise stay.
- ONE, in_fire & out_fire -> ONE, main <= inputs.
- ONE, in_fire & !out_fire -> TWO, skid <= inputs.
- ONE, !in_fire & out_fire -> EMPTY. Otherwise hold.
- TWO: ready_o=0, so in_fire cannot occur. out_fire -> ONE, main <= skid. Otherwise hold.
- Latency: beat accepted in cycle N appears on valid_o in cycle N+1 when stage was EMPTY, or in ONE with out_fire. Sustained throughput is 1 beat/cycle.
- Ordering: strictly FIFO; no beat is duplicated or dropped except by flush.
- flush: highest priority over all handshakes. Next state is EMPTY and both valid bits clear.
  - Any beat offered in the same cycle is discarded, even if ready_o=1.
  - InsM and skid Ins <= 0 (NOP); PC8M and skid PC8 <= RESET_PC. ALUOutM and WriteDataM hold.
  - An out_fire in the flush cycle still counts as consumed by MEM.
- rst (async, any time including mid-transfer): state EMPTY, valid_o=0, ready_o=1.
  - ALUOutM=0, WriteDataM=0, PC8M=RESET_PC, InsM=0; skid fields reset to the same values.
- When valid_o=0, data outputs hold their last value (or reset/flush values); MEM must qualify them with valid_o.
- Widths are fixed per field; no arithmetic is performed on data.

Optional Feature:
STALL_CNT_EN
- Defined: adds output stall_cnt [31:0]. It increments each cycle with valid_o & !ready_i and saturates at 32'hFFFFFFFF. Cleared only by rst, not by flush.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> valid_o=0, ready_o=1, PC8M=32'h00003000, InsM=0, ALUOutM=0, all immediately, without waiting for a clock edge.
- Streaming: ready_i=1, valid_i=1 for 8 cycles with Ins=1..8 -> InsM=1..8 on consecutive cycles starting 1 cycle after first beat; ready_o stays 1.
- Back-pressure: ready_i=0, send Ins=A then B -> InsM=A, ready_o=0 after B accepted, B not lost. Then ready_i=1 -> InsM=B next cycle, ready_o=1.
- Flush in TWO: hold A and B, assert flush with valid_i=1 (Ins=C) -> next cycle valid_o=0, InsM=0, PC8M=RESET_PC. C is never output.
- Reset mid-operation: in TWO, pulse rst -> EMPTY. Later beat D streams normally with 1-cycle latency.
- STALL_CNT_EN: valid_o=1, ready_i=0 for 5 cycles -> stall_cnt=5. Flush leaves it at 5; rst clears it to 0.
